// File: rtl/adrv9009_rx_dc_corr.sv
// -----------------------------------------------------------------------------
// adrv9009_rx_dc_corr
//
// Rx DC-offset estimator and corrector. It sits between the RFIR output and the
// Rx framer. Valid samples are averaged over fixed blocks of 2^LOG2_BLK
// samples. The first ACQ_BLOCKS block means are loaded straight into the
// estimate (ACQUIRE). After that the estimate moves a fraction
// 2^-SHIFT_TRACK of the way toward each new block mean (TRACK). Every valid
// input produces one saturated output, out = in - dc_est, one clock later.
//
// Ports
//   clk        sample clock
//   reset      asynchronous, active-high
//   enable     1 = estimate and correct, 0 = bypass (IDLE, estimate cleared)
//   hold       1 = freeze estimate updates while tracking
//   in         signed sample from RFIR, qualified by in_valid
//   out        signed corrected sample, qualified by out_valid
//                (out holds its value while out_valid is 0)
//   dc_est     current signed DC estimate
//   locked     1 while tracking
//
// Build option
//   ADRV9009_DC_CORR_ROUND_EN : when defined, the block mean and the tracking
//   step round half up. When it is not defined, both are plain arithmetic
//   shifts, which truncate toward -inf.
// -----------------------------------------------------------------------------
module adrv9009_rx_dc_corr #(
  parameter int WIDTH       = 16,
  parameter int LOG2_BLK    = 10,
  parameter int ACQ_BLOCKS  = 4,
  parameter int SHIFT_TRACK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    hold,
  input  logic signed [WIDTH-1:0] in,
  input  logic                    in_valid,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] dc_est,
  output logic                    locked
);

  localparam int ACC_W = WIDTH + LOG2_BLK;
  localparam int BLK_W = $clog2(ACQ_BLOCKS + 1);

  // Rounding offsets. Each is half of the divisor, and is zero when rounding
  // is disabled. Writing 2**n/2 also gives 0 when the shift is 0.
`ifdef ADRV9009_DC_CORR_ROUND_EN
  localparam logic signed [ACC_W:0]   MEAN_RND = (ACC_W+1)'(2 ** LOG2_BLK / 2);
  localparam logic signed [WIDTH+1:0] TRK_RND  = (WIDTH+2)'(2 ** SHIFT_TRACK / 2);
`else
  localparam logic signed [ACC_W:0]   MEAN_RND = '0;
  localparam logic signed [WIDTH+1:0] TRK_RND  = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [LOG2_BLK-1:0]     smp_cnt_reg;
  logic [BLK_W-1:0]        blk_cnt_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [WIDTH-1:0] dc_est_reg, dc_est_next;
  logic signed [WIDTH-1:0] out_reg;
  logic                    out_valid_reg;

  logic                    blk_end;
  logic                    acq_done;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W:0]   mean_sum;
  logic signed [ACC_W:0]   mean_shift;
  logic signed [WIDTH-1:0] mean;
  logic signed [WIDTH:0]   trk_diff;
  logic signed [WIDTH+1:0] trk_sum;
  logic signed [WIDTH+1:0] trk_step;
  logic signed [WIDTH+1:0] est_trk;
  logic signed [WIDTH:0]   sub_full;
  logic signed [WIDTH-1:0] sat_out;
  logic                    unused_bits;

  // --------------------------------------------------------------------------
  // Correction path: subtract with one guard bit, then clamp.
  // --------------------------------------------------------------------------
  assign sub_full = $signed({in[WIDTH-1], in}) - $signed({dc_est_reg[WIDTH-1], dc_est_reg});

  always_comb begin
    sat_out = sub_full[WIDTH-1:0];
    // The top two bits differ only when the result left the WIDTH-bit range.
    if (sub_full[WIDTH] != sub_full[WIDTH-1])
      sat_out = sub_full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // --------------------------------------------------------------------------
  // Block averaging. acc_sum already includes the current sample, so the
  // sample that closes the block is part of its own mean.
  // --------------------------------------------------------------------------
  assign acc_sum    = acc_reg + $signed({{LOG2_BLK{in[WIDTH-1]}}, in});
  assign mean_sum   = $signed({acc_sum[ACC_W-1], acc_sum}) + MEAN_RND;
  assign mean_shift = mean_sum >>> LOG2_BLK;
  assign mean       = mean_shift[WIDTH-1:0];

  assign blk_end  = in_valid && (state_reg != S_IDLE) && (smp_cnt_reg == '1);
  assign acq_done = blk_end && (state_reg == S_ACQ) &&
                    (blk_cnt_reg == BLK_W'(ACQ_BLOCKS - 1));

  // Tracking step. The new estimate always lies between the old estimate and
  // the mean, so truncating back to WIDTH bits cannot wrap.
  assign trk_diff = $signed({mean[WIDTH-1], mean}) - $signed({dc_est_reg[WIDTH-1], dc_est_reg});
  assign trk_sum  = $signed({trk_diff[WIDTH], trk_diff}) + TRK_RND;
  assign trk_step = trk_sum >>> SHIFT_TRACK;
  assign est_trk  = $signed({{2{dc_est_reg[WIDTH-1]}}, dc_est_reg}) + trk_step;

  assign unused_bits = ^{mean_shift[ACC_W:WIDTH], est_trk[WIDTH+1:WIDTH]};

  // Candidate estimate. It is only loaded at a block end.
  always_comb begin
    dc_est_next = dc_est_reg;
    if (state_reg == S_ACQ)
      dc_est_next = mean;
    else if ((state_reg == S_TRACK) && !hold)
      dc_est_next = est_trk[WIDTH-1:0];
  end

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  state_next = S_ACQ;
        S_ACQ:   if (acq_done) state_next = S_TRACK;
        S_TRACK: state_next = S_TRACK;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    locked = (state_reg == S_TRACK);
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      acc_reg       <= '0;
      smp_cnt_reg   <= '0;
      blk_cnt_reg   <= '0;
      dc_est_reg    <= '0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid)
        out_reg <= sat_out;

      // Dropping enable discards everything, including a partial block. The
      // sample on that edge has already been corrected with the old estimate.
      if (!enable || (state_reg == S_IDLE)) begin
        acc_reg     <= '0;
        smp_cnt_reg <= '0;
        blk_cnt_reg <= '0;
        dc_est_reg  <= '0;
      end else if (in_valid) begin
        if (blk_end) begin
          acc_reg     <= '0;
          smp_cnt_reg <= '0;
          dc_est_reg  <= dc_est_next;
          if (state_reg == S_ACQ)
            blk_cnt_reg <= blk_cnt_reg + BLK_W'(1);
        end else begin
          acc_reg     <= acc_sum;
          smp_cnt_reg <= smp_cnt_reg + LOG2_BLK'(1);
        end
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign dc_est    = dc_est_reg;

endmodule

// File: tb/tb_adrv9009_rx_dc_corr.sv
`timescale 1ns/1ps
module tb_adrv9009_rx_dc_corr;

  localparam int WIDTH       = 16;
  localparam int LOG2_BLK    = 4;
  localparam int ACQ_BLOCKS  = 2;
  localparam int SHIFT_TRACK = 2;
  localparam int BLK_LEN     = 1 << LOG2_BLK;
  localparam int TRK_DIV     = 1 << SHIFT_TRACK;
  localparam int MAX_V       = 32767;
  localparam int MIN_V       = -32768;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    enable = 1'b0;
  logic                    hold = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [WIDTH-1:0] in_s = '0;
  logic signed [WIDTH-1:0] out_s;
  logic signed [WIDTH-1:0] dc_est_s;
  logic                    out_valid;
  logic                    locked;

  always #5 clk = ~clk;

  adrv9009_rx_dc_corr #(
    .WIDTH(WIDTH), .LOG2_BLK(LOG2_BLK), .ACQ_BLOCKS(ACQ_BLOCKS), .SHIFT_TRACK(SHIFT_TRACK)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold),
    .in(in_s), .in_valid(in_valid),
    .out(out_s), .out_valid(out_valid), .dc_est(dc_est_s), .locked(locked)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (block-level arithmetic) ----------------
  typedef struct {
    bit ov;
    int est;
    bit lk;
    int held;
  } status_t;

  status_t st_q[$];   // per-clock expected status
  int      out_q[$];  // expected corrected samples, one per valid input

  int m_mode = 0;     // 0 bypass, 1 acquiring, 2 tracking
  int m_est = 0;
  int m_nblk = 0;
  int m_last_out = 0;
  int m_blk[$];       // valid samples of the current block

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int sat(input int v);
    if (v > MAX_V) return MAX_V;
    if (v < MIN_V) return MIN_V;
    return v;
  endfunction

  function automatic int block_mean(input int samples[$]);
    int sum;
    sum = 0;
    foreach (samples[k]) sum += samples[k];
`ifdef ADRV9009_DC_CORR_ROUND_EN
    sum += BLK_LEN / 2;
`endif
    return floor_div(sum, BLK_LEN);
  endfunction

  function automatic int track_step(input int diff);
    int d;
    d = diff;
`ifdef ADRV9009_DC_CORR_ROUND_EN
    d += TRK_DIV / 2;
`endif
    return floor_div(d, TRK_DIV);
  endfunction

  // Advance the model by one clock with the given inputs and queue what the
  // DUT must show after that edge.
  task automatic model_clock(input bit en, input bit hd, input bit v, input int x);
    status_t s;
    int mean;
    if (v) begin
      m_last_out = sat(x - m_est);
      out_q.push_back(m_last_out);
    end
    if (!en) begin
      m_mode = 0; m_est = 0; m_nblk = 0; m_blk.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (v) begin
      m_blk.push_back(x);
      if (m_blk.size() == BLK_LEN) begin
        mean = block_mean(m_blk);
        m_blk.delete();
        if (m_mode == 1) begin
          m_est = mean;
          m_nblk++;
          if (m_nblk == ACQ_BLOCKS) m_mode = 2;
        end else if (!hd) begin
          m_est = m_est + track_step(mean - m_est);
        end
      end
    end
    s.ov = v; s.est = m_est; s.lk = (m_mode == 2); s.held = m_last_out;
    st_q.push_back(s);
  endtask

  // ---------------- monitor ----------------
  status_t s_mon;
  int      exp_out;
  int      n_out = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (st_q.size() > 0) begin
        s_mon = st_q.pop_front();
        check("out_valid", int'(out_valid), int'(s_mon.ov));
        check("dc_est", int'(dc_est_s), s_mon.est);
        check("locked", int'(locked), int'(s_mon.lk));
        if (out_valid) begin
          if (out_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL out_extra: got output %0d, required none", int'(out_s));
          end else begin
            exp_out = out_q.pop_front();
            check("out", int'(out_s), exp_out);
            n_out++;
            $display("[TB] sample %0d: out=%0d exp=%0d dc_est=%0d locked=%0b",
                     n_out, int'(out_s), exp_out, int'(dc_est_s), locked);
          end
        end else begin
          check("out_hold", int'(out_s), s_mon.held);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit en, input bit hd, input bit v, input int x);
    @(negedge clk); #1;
    enable = en; hold = hd; in_valid = v; in_s = WIDTH'(x);
    model_clock(en, hd, v, x);
  endtask

  task automatic apply_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_out", int'(out_s), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dc_est", int'(dc_est_s), 0);
    check("rst_locked", int'(locked), 0);
    enable = 1'b0; hold = 1'b0; in_valid = 1'b0; in_s = '0;
    m_mode = 0; m_est = 0; m_nblk = 0; m_last_out = 0; m_blk.delete();
    st_q.delete(); out_q.delete();
    @(negedge clk); #1;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic int rand_full();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int dc;
  bit en_r, hd_r, v_r;
  int x_r;

  initial begin : stimulus
    apply_reset();

    // 1: reset in the middle of an acquisition block, then bypass
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 1, int'($urandom_range(0, 400)) - 200);
    apply_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 1, rand_full());

    // 2: constant 100, acquire and lock
    step(1, 0, 0, 0);
    for (int i = 0; i < 48; i++) step(1, 0, 1, 100);
    step(1, 0, 0, 0);
    check("acq_est_100", int'(dc_est_s), 100);
    check("acq_locked", int'(locked), 1);
    check("acq_out_zero", int'(out_s), 0);

    // 3: step to 200 while tracking, then hold, then drop enable mid-block
    for (int i = 0; i < 4 * BLK_LEN; i++) step(1, 0, 1, 200);
    for (int i = 0; i < 2 * BLK_LEN; i++) step(1, 1, 1, 200);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 200);
    step(0, 0, 1, 200);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 200);
    check("idle_est", int'(dc_est_s), 0);
    check("idle_locked", int'(locked), 0);

    // 4: saturation in both directions
    step(1, 0, 0, 0);
    for (int i = 0; i < 2 * BLK_LEN; i++) step(1, 0, 1, -1000);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 32000);
    step(1, 0, 0, 0);
    check("sat_pos", int'(out_s), MAX_V);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 2 * BLK_LEN; i++) step(1, 0, 1, 100);
    for (int i = 0; i < 3; i++) step(1, 0, 1, -32768);
    step(1, 0, 0, 0);
    check("sat_neg", int'(out_s), MIN_V);

    // 5: one valid sample every third clock
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3 * 40; i++)
      step(1, 0, (i % 3) == 0, ((i % 3) == 0) ? 50 : rand_full());
    step(1, 0, 0, 0);
    check("sparse_est_50", int'(dc_est_s), 50);

    // 6: mean rounding on alternating patterns
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 2 * BLK_LEN; i++) step(1, 0, 1, i % 2);
    step(1, 0, 0, 0);
`ifdef ADRV9009_DC_CORR_ROUND_EN
    check("alt_pos_est", int'(dc_est_s), 1);
`else
    check("alt_pos_est", int'(dc_est_s), 0);
`endif
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 2 * BLK_LEN; i++) step(1, 0, 1, -(i % 2));
    step(1, 0, 0, 0);
`ifdef ADRV9009_DC_CORR_ROUND_EN
    check("alt_neg_est", int'(dc_est_s), 0);
`else
    check("alt_neg_est", int'(dc_est_s), -1);
`endif

    // Random: wandering DC with noise, gaps, hold and occasional disable
    dc = 0;
    for (int i = 0; i < 900; i++) begin
      if (i % 150 == 0) dc = int'($urandom_range(0, 8000)) - 4000;
      en_r = ($urandom_range(0, 99) != 0);
      hd_r = ($urandom_range(0, 5) == 0);
      v_r  = ($urandom_range(0, 3) != 0);
      x_r  = ($urandom_range(0, 15) == 0) ? rand_full() : dc + int'($urandom_range(0, 300)) - 150;
      step(en_r, hd_r, v_r, x_r);
    end

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk); #2;
    check("drain", st_q.size() + out_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
